// File: rtl/pzcorebus_pkg.sv
// -----------------------------------------------------------------------------
// pzcorebus_pkg
// Shared helpers for the corebus FIFO family.
//   get_fifo_count_width(depth) : bits needed to hold an occupancy of 0..depth
//   get_fifo_ptr_width(depth)   : bits needed to address entries 0..depth-1
// -----------------------------------------------------------------------------
package pzcorebus_pkg;

  function automatic int get_fifo_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A depth of 2 still needs one address bit.
  function automatic int get_fifo_ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pzcorebus_response_packet_fifo_ram.sv
// -----------------------------------------------------------------------------
// pzcorebus_response_packet_fifo_ram
// DEPTH x WIDTH storage for the response packet FIFO. The write is synchronous
// and the read is asynchronous.
//   i_clk, i_rst : clock and synchronous active-high reset (reset clears the
//                  array only when RESET_DATA=1)
//   i_we         : write enable
//   i_waddr      : write address
//   i_wdata      : write data
//   i_raddr      : read address
//   o_rdata      : combinational read data
// -----------------------------------------------------------------------------
module pzcorebus_response_packet_fifo_ram
  import pzcorebus_pkg::*;
#(
  parameter int WIDTH      = 65,
  parameter int DEPTH      = 8,
  parameter int RESET_DATA = 0,
  localparam int ADDR_W    = get_fifo_ptr_width(DEPTH)
)(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if ((RESET_DATA != 0) && i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pzcorebus_response_packet_fifo.sv
// -----------------------------------------------------------------------------
// pzcorebus_response_packet_fifo
// Burst-aware response FIFO between a corebus response source and sink.
// Cut-through mode presents any stored beat. Store-and-forward mode holds the
// output until a whole burst (through its last beat) is stored. A burst longer
// than DEPTH can never complete, so once the FIFO is full with no complete
// packet it is released (cut-through until that burst's last beat leaves) and
// the sticky o_stall_error flag is raised.
//   i_clk, i_rst, i_clear                    : clock, sync reset, sync flush
//   i_sresp_valid/o_mresp_accept             : upstream handshake
//   i_sresp, i_sresp_last                    : upstream beat
//   o_sresp_valid/i_mresp_accept             : downstream handshake
//   o_sresp, o_sresp_last                    : head beat
//   o_empty, o_almost_full, o_full           : registered occupancy flags
//   o_word_count, o_packet_count             : stored beats / stored last beats
//   o_stall_error                            : sticky forced-release indicator
// -----------------------------------------------------------------------------
module pzcorebus_response_packet_fifo
  import pzcorebus_pkg::*;
#(
  parameter int WIDTH             = 64,
  parameter int DEPTH             = 8,
  parameter int THRESHOLD         = DEPTH,
  parameter int STORE_AND_FORWARD = 0,
  parameter int RESET_DATA        = 0,
  localparam int COUNT_WIDTH      = get_fifo_count_width(DEPTH)
)(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_sresp_valid,
  output logic                   o_mresp_accept,
  input  logic [WIDTH-1:0]       i_sresp,
  input  logic                   i_sresp_last,
  output logic                   o_sresp_valid,
  input  logic                   i_mresp_accept,
  output logic [WIDTH-1:0]       o_sresp,
  output logic                   o_sresp_last,
  output logic                   o_empty,
  output logic                   o_almost_full,
  output logic                   o_full,
  output logic [COUNT_WIDTH-1:0] o_word_count,
  output logic [COUNT_WIDTH-1:0] o_packet_count,
  output logic                   o_stall_error
);

  localparam int PTR_W   = get_fifo_ptr_width(DEPTH);
  localparam int ENTRY_W = WIDTH + 1;

  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [COUNT_WIDTH-1:0] r_word_count;
  logic [COUNT_WIDTH-1:0] r_packet_count;
  logic                   r_empty;
  logic                   r_almost_full;
  logic                   r_full;
  logic                   r_release;
  logic                   r_stall_error;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_push_last;
  logic                   w_pop_last;
  logic                   w_sresp_valid;
  logic                   w_release_set;
  logic [ENTRY_W-1:0]     w_rdata;
  logic                   w_head_last;
  logic [WIDTH-1:0]       w_head_data;
  logic [COUNT_WIDTH-1:0] w_word_count_next;
  logic [COUNT_WIDTH-1:0] w_packet_count_next;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Clear wins over any handshake in the same cycle, so both are gated.
  assign w_push      = i_sresp_valid && !r_full && !i_clear;
  assign w_pop       = w_sresp_valid && i_mresp_accept && !i_clear;
  assign w_push_last = w_push && i_sresp_last;
  assign w_pop_last  = w_pop && w_head_last;

  pzcorebus_response_packet_fifo_ram #(
    .WIDTH      (ENTRY_W),
    .DEPTH      (DEPTH),
    .RESET_DATA (RESET_DATA)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({i_sresp_last, i_sresp}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign {w_head_last, w_head_data} = w_rdata;

  // Store-and-forward exposes the head only when a complete packet is held or
  // an oversize burst has been forced through.
  assign w_sresp_valid = (STORE_AND_FORWARD != 0) ? ((r_packet_count != '0) || r_release)
                                                  : !r_empty;

  // Full with no last beat stored means the burst can never complete here.
  assign w_release_set = (STORE_AND_FORWARD != 0) && r_full && (r_packet_count == '0);

  always_comb begin
    w_word_count_next = r_word_count;
    case ({w_push, w_pop})
      2'b10:   w_word_count_next = r_word_count + COUNT_WIDTH'(1);
      2'b01:   w_word_count_next = r_word_count - COUNT_WIDTH'(1);
      default: w_word_count_next = r_word_count;
    endcase
  end

  always_comb begin
    w_packet_count_next = r_packet_count;
    case ({w_push_last, w_pop_last})
      2'b10:   w_packet_count_next = r_packet_count + COUNT_WIDTH'(1);
      2'b01:   w_packet_count_next = r_packet_count - COUNT_WIDTH'(1);
      default: w_packet_count_next = r_packet_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_word_count   <= '0;
      r_packet_count <= '0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_full         <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      r_word_count   <= w_word_count_next;
      r_packet_count <= w_packet_count_next;
      r_empty        <= (w_word_count_next == '0);
      r_almost_full  <= (w_word_count_next >= COUNT_WIDTH'(THRESHOLD));
      r_full         <= (w_word_count_next == COUNT_WIDTH'(DEPTH));
    end
  end

  // Release holds until the oversize burst's last beat is popped. When the set
  // condition holds no last beat is stored, so set and clear cannot coincide.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_release     <= 1'b0;
      r_stall_error <= 1'b0;
    end else if (w_release_set) begin
      r_release     <= 1'b1;
      r_stall_error <= 1'b1;
    end else if (w_pop_last) begin
      r_release     <= 1'b0;
    end
  end

  assign o_mresp_accept = !r_full;
  assign o_sresp_valid  = w_sresp_valid;
  assign o_sresp        = w_head_data;
  assign o_sresp_last   = w_head_last;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_almost_full;
  assign o_full         = r_full;
  assign o_word_count   = r_word_count;
  assign o_packet_count = r_packet_count;
  assign o_stall_error  = r_stall_error;

endmodule

// File: tb/tb_pzcorebus_response_packet_fifo.sv
// Two instances: A is cut-through (DEPTH=5, THRESHOLD=5, RESET_DATA=1) and
// B is store-and-forward (DEPTH=4, THRESHOLD=3). Stimulus queues expected beats;
// per-instance monitors pop and compare whenever a pop handshake is presented.
module tb_pzcorebus_response_packet_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_clear, a_svalid, a_slast, a_macc;
  logic [63:0] a_sdata;
  logic        a_accept, a_valid, a_last, a_empty, a_afull, a_full, a_stall;
  logic [63:0] a_rdata;
  logic [2:0]  a_wc, a_pc;

  logic        b_clear, b_svalid, b_slast, b_macc;
  logic [63:0] b_sdata;
  logic        b_accept, b_valid, b_last, b_empty, b_afull, b_full, b_stall;
  logic [63:0] b_rdata;
  logic [2:0]  b_wc, b_pc;

  int checks   = 0;
  int failures = 0;

  logic [64:0] qa[$];
  logic [64:0] qb[$];
  logic [64:0] a_exp, b_exp;

  pzcorebus_response_packet_fifo #(
    .WIDTH(64), .DEPTH(5), .THRESHOLD(5), .STORE_AND_FORWARD(0), .RESET_DATA(1)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_clear(a_clear),
    .i_sresp_valid(a_svalid), .o_mresp_accept(a_accept),
    .i_sresp(a_sdata), .i_sresp_last(a_slast),
    .o_sresp_valid(a_valid), .i_mresp_accept(a_macc),
    .o_sresp(a_rdata), .o_sresp_last(a_last),
    .o_empty(a_empty), .o_almost_full(a_afull), .o_full(a_full),
    .o_word_count(a_wc), .o_packet_count(a_pc), .o_stall_error(a_stall)
  );

  pzcorebus_response_packet_fifo #(
    .WIDTH(64), .DEPTH(4), .THRESHOLD(3), .STORE_AND_FORWARD(1), .RESET_DATA(0)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_clear(b_clear),
    .i_sresp_valid(b_svalid), .o_mresp_accept(b_accept),
    .i_sresp(b_sdata), .i_sresp_last(b_slast),
    .o_sresp_valid(b_valid), .i_mresp_accept(b_macc),
    .o_sresp(b_rdata), .o_sresp_last(b_last),
    .o_empty(b_empty), .o_almost_full(b_afull), .o_full(b_full),
    .o_word_count(b_wc), .o_packet_count(b_pc), .o_stall_error(b_stall)
  );

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a pop happens at the next posedge when valid & accept & !clear.
  always @(negedge clk) begin
    if (!rst && !a_clear && a_valid && a_macc) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_pop_unexpected actual=%0h required=none", a_rdata);
      end else begin
        a_exp = qa.pop_front();
        chk("a_pop_beat", {a_last, a_rdata}, a_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !b_clear && b_valid && b_macc) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_pop_unexpected actual=%0h required=none", b_rdata);
      end else begin
        b_exp = qb.pop_front();
        chk("b_pop_beat", {b_last, b_rdata}, b_exp);
      end
    end
  end

  // Offer one beat to B, holding it until accepted or the bound expires.
  task automatic send_b(input logic [63:0] data, input logic last);
    int n;
    b_svalid = 1'b1;
    b_sdata  = data;
    b_slast  = last;
    n = 0;
    while (!b_accept && n < 20) begin
      tick();
      n++;
    end
    if (!b_accept) begin
      chk("b_send_timeout", 65'(n), 65'(0));
    end else begin
      qb.push_back({last, data});
      tick();
    end
    b_svalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mcnt, sent, n;
    logic acc, pushok, popok;

    rst = 1'b1;
    a_clear = 0; a_svalid = 0; a_slast = 0; a_macc = 0; a_sdata = '0;
    b_clear = 0; b_svalid = 0; b_slast = 0; b_macc = 0; b_sdata = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("a_rst_empty", a_empty, 1);
    chk("a_rst_valid", a_valid, 0);
    chk("a_rst_wc", a_wc, 0);
    chk("a_rst_afull", a_afull, 0);
    chk("a_rst_full", a_full, 0);
    chk("a_rst_accept", a_accept, 1);
    chk("b_rst_empty", b_empty, 1);
    chk("b_rst_pc", b_pc, 0);
    chk("b_rst_stall", b_stall, 0);
    chk("b_rst_valid", b_valid, 0);

    // Cut-through: one-cycle latency, no bypass
    a_svalid = 1; a_sdata = 64'h11; a_slast = 1;
    qa.push_back({1'b1, 64'h11});
    chk("a_no_bypass", a_valid, 0);
    tick();
    a_svalid = 0;
    chk("a_ct_valid", a_valid, 1);
    chk("a_ct_data", a_rdata, 64'h11);
    chk("a_ct_last", a_last, 1);
    chk("a_ct_wc1", a_wc, 1);
    a_macc = 1;
    tick();
    a_macc = 0;
    chk("a_ct_wc0", a_wc, 0);
    chk("a_ct_empty", a_empty, 1);
    chk("a_ct_valid0", a_valid, 0);

    // Store-and-forward: 3-beat burst held until last beat stored
    b_macc = 1;
    for (int i = 0; i < 3; i++) begin
      b_svalid = 1; b_sdata = 64'hA0 + 64'(i); b_slast = (i == 2);
      qb.push_back({(i == 2), 64'hA0 + 64'(i)});
      tick();
      chk("b_saf_valid", b_valid, (i == 2));
    end
    b_svalid = 0;
    chk("b_saf_pc1", b_pc, 1);
    chk("b_saf_wc3", b_wc, 3);
    for (int i = 0; i < 3; i++) begin
      chk("b_saf_stream", b_valid, 1);
      tick();
    end
    b_macc = 0;
    chk("b_saf_pc0", b_pc, 0);
    chk("b_saf_valid0", b_valid, 0);

    // Fill B with four 1-beat packets, accept held low
    for (int i = 0; i < 4; i++) begin
      b_svalid = 1; b_sdata = 64'hB0 + 64'(i); b_slast = 1;
      qb.push_back({1'b1, 64'hB0 + 64'(i)});
      tick();
      chk("b_fill_afull", b_afull, (i >= 2));
      chk("b_fill_full", b_full, (i == 3));
    end
    chk("b_full_accept", b_accept, 0);
    chk("b_full_pc", b_pc, 4);
    chk("b_full_wc", b_wc, 4);
    // Push and pop together while full: only the pop happens
    b_svalid = 1; b_sdata = 64'hBF; b_slast = 1; b_macc = 1;
    tick();
    b_svalid = 0; b_macc = 0;
    chk("b_fullpp_wc", b_wc, 3);
    chk("b_fullpp_pc", b_pc, 3);
    chk("b_fullpp_full", b_full, 0);
    chk("b_fullpp_accept", b_accept, 1);
    b_macc = 1;
    repeat (3) tick();
    b_macc = 0;
    chk("b_drain_empty", b_empty, 1);

    // Oversize 6-beat burst forces release
    b_macc = 1;
    for (int i = 0; i < 6; i++) begin
      send_b(64'hC0 + 64'(i), (i == 5));
    end
    chk("b_long_stall", b_stall, 1);
    n = 0;
    while (qb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    b_macc = 0;
    chk("b_long_drained", 65'(qb.size()), 0);
    chk("b_long_valid0", b_valid, 0);
    chk("b_long_wc0", b_wc, 0);
    chk("b_long_stall_sticky", b_stall, 1);

    // Clear beats a simultaneous push and pop
    for (int i = 0; i < 2; i++) begin
      b_svalid = 1; b_sdata = 64'hD0 + 64'(i); b_slast = 1;
      qb.push_back({1'b1, 64'hD0 + 64'(i)});
      tick();
    end
    chk("b_clr_pre_wc", b_wc, 2);
    b_clear = 1; b_svalid = 1; b_sdata = 64'hD2; b_macc = 1;
    tick();
    b_clear = 0; b_svalid = 0; b_macc = 0;
    qb.delete();
    chk("b_clr_wc", b_wc, 0);
    chk("b_clr_pc", b_pc, 0);
    chk("b_clr_empty", b_empty, 1);
    chk("b_clr_stall", b_stall, 0);
    chk("b_clr_valid", b_valid, 0);

    // Wrap-around on DEPTH=5 with random downstream accept
    mcnt = 0;
    sent = 0;
    for (int cyc = 0; cyc < 400 && (sent < 17 || mcnt > 0); cyc++) begin
      acc = ($urandom_range(0, 2) == 0);
      a_svalid = (sent < 17);
      a_sdata  = 64'h100 + 64'(sent);
      a_slast  = 1;
      a_macc   = acc;
      pushok = (sent < 17) && (mcnt < 5);
      popok  = acc && (mcnt > 0);
      chk("a_wrap_accept", a_accept, (mcnt < 5));
      if (pushok) begin
        qa.push_back({1'b1, 64'h100 + 64'(sent)});
        sent++;
      end
      tick();
      mcnt = mcnt + int'(pushok) - int'(popok);
      chk("a_wrap_wc", a_wc, 65'(mcnt));
    end
    a_svalid = 0; a_macc = 0;
    chk("a_wrap_sent", 65'(sent), 17);
    chk("a_wrap_drained", 65'(qa.size()), 0);
    chk("a_wrap_empty", a_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
